// File: rtl/adder_operand_server.sv
// adder_operand_server: memory-side responder for the word-serial adder.
// Holds operand banks m0/m1 and a result bank, serves registered operand
// words to the adder, captures its result writes and sequences one run.
module adder_operand_server #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int AW         = 7
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  host_we,
    input  logic                  host_bank,
    input  logic [AW-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_re,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic [31:0]           host_len,
    input  logic                  host_go,
    input  logic                  host_clr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           wr_count,
    output logic                  add_start,
    output logic [31:0]           two_times_len_1,
    input  logic                  read_en,
    input  logic [31:0]           read_addr,
    output logic [DATA_WIDTH-1:0] m0,
    output logic [DATA_WIDTH-1:0] m1,
    input  logic                  result_valid,
    input  logic [31:0]           result_addr,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  add_complete
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] bank0 [DEPTH];
    logic [DATA_WIDTH-1:0] bank1 [DEPTH];
    logic [DATA_WIDTH-1:0] rbank [DEPTH];

    logic [33:0] read_limit;
    logic        read_in_range;
    logic        res_in_range;
    logic        host_in_range;
    logic        host_write_ok;
    logic        result_write_ok;
    logic        go_accept;
    logic        err_set;

    // Operand words past 2*(len+1) are the carry-extension words and read as zero;
    // the limit is computed two bits wider so a large length code cannot wrap.
    assign read_limit      = ({2'b00, two_times_len_1} + 34'd1) << 1;
    assign read_in_range   = ({2'b00, read_addr} < read_limit) && (read_addr < 32'(DEPTH));
    assign res_in_range    = result_addr < 32'(DEPTH);
    assign host_in_range   = 32'(host_addr) < 32'(DEPTH);
    assign host_write_ok   = host_we && host_in_range && (state == IDLE || state == DONE);
    assign result_write_ok = result_valid && res_in_range && (state == BUSY);
    assign go_accept       = (state == IDLE) && host_go && !host_clr;
    assign err_set         = (host_we && (state == START || state == BUSY))
                           || (result_valid && (state != BUSY || !res_in_range));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; host_clr overrides everything and returns to IDLE
    always_comb begin
        next_state = state;
        if (host_clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (host_go) next_state = START;
                START:   next_state = BUSY;
                BUSY:    if (add_complete) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state; a clear in START suppresses the start pulse
    always_comb begin
        busy      = (state == START) || (state == BUSY);
        done      = (state == DONE);
        add_start = (state == START) && !host_clr;
    end

    // Length latch and result-word counter for the current run
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            two_times_len_1 <= '0;
            wr_count        <= '0;
        end else if (go_accept) begin
            two_times_len_1 <= host_len;
            wr_count        <= '0;
        end else if (result_valid && state == BUSY) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // Sticky protocol-error flag; a new error in the clearing cycle still registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)        err <= 1'b0;
        else if (err_set)  err <= 1'b1;
        else if (host_clr) err <= 1'b0;
    end

    // Bank storage writes (contents deliberately survive reset)
    always_ff @(posedge CLK) begin
        if (host_write_ok) begin
            if (host_bank) bank1[host_addr] <= host_wdata;
            else           bank0[host_addr] <= host_wdata;
        end
        if (result_write_ok) begin
            rbank[result_addr[AW-1:0]] <= result;
        end
    end

    // Registered operand read port: one-cycle latency, holds when not requested
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m0 <= '0;
            m1 <= '0;
        end else if (read_en) begin
            m0 <= read_in_range ? bank0[read_addr[AW-1:0]] : '0;
            m1 <= read_in_range ? bank1[read_addr[AW-1:0]] : '0;
        end
    end

    // Registered host result read; a same-cycle adder write is seen next time
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            host_rdata <= '0;
        end else if (host_re) begin
            host_rdata <= host_in_range ? rbank[host_addr] : '0;
        end
    end

endmodule
